// File: rtl/wb_port_arbiter_pkg.sv
// Shared widths, load-extension codes and the load-return FIFO entry layout
// for the register-file write-port arbiter.
package wb_port_arbiter_pkg;

   localparam int unsigned GPR_ADDR_LEN = 5;
   localparam int unsigned DATA_LEN     = 32;
   localparam int unsigned OFFSET_LEN   = 2;
   localparam int unsigned REG_EXT_LEN  = 3;

   localparam logic [REG_EXT_LEN-1:0] REG_EXT_NONE   = REG_EXT_LEN'(0);
   localparam logic [REG_EXT_LEN-1:0] REG_EXT_BYTE   = REG_EXT_LEN'(1);
   localparam logic [REG_EXT_LEN-1:0] REG_EXT_BYTE_U = REG_EXT_LEN'(2);
   localparam logic [REG_EXT_LEN-1:0] REG_EXT_HALF   = REG_EXT_LEN'(3);
   localparam logic [REG_EXT_LEN-1:0] REG_EXT_HALF_U = REG_EXT_LEN'(4);

   typedef struct packed {
      logic [GPR_ADDR_LEN-1:0] addr;
      logic [DATA_LEN-1:0]     data;
      logic [OFFSET_LEN-1:0]   offset;
      logic [REG_EXT_LEN-1:0]  ext;
   } ld_entry_t;

endpackage

// File: rtl/load_align_ext.sv
// Combinational byte/half alignment and sign/zero extension of a returned load word.
module load_align_ext
   import wb_port_arbiter_pkg::*;
(
   input  logic [DATA_LEN-1:0]    data,
   input  logic [OFFSET_LEN-1:0]  offset,
   input  logic [REG_EXT_LEN-1:0] ext,
   output logic [DATA_LEN-1:0]    data_c
);

   logic [DATA_LEN-1:0] shifted;

   always_comb begin
      shifted = data >> {offset, 3'b000};
      data_c  = '0;
      case (ext)
         REG_EXT_NONE:   data_c = data;
         REG_EXT_BYTE:   data_c = {{24{shifted[7]}}, shifted[7:0]};
         REG_EXT_BYTE_U: data_c = {24'h0, shifted[7:0]};
         // halfword loads must be halfword aligned; a misaligned one writes zero
         REG_EXT_HALF:   if (!offset[0]) data_c = {{16{shifted[15]}}, shifted[15:0]};
         REG_EXT_HALF_U: if (!offset[0]) data_c = {16'h0, shifted[15:0]};
         default:        data_c = '0;
      endcase
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the register-file write port between the W stage and a small FIFO of
// late load returns; tracks outstanding loads and forces a drain on starvation.
module wb_port_arbiter
   import wb_port_arbiter_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH   = 2,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    w_we,
   input  logic [GPR_ADDR_LEN-1:0] w_addr,
   input  logic [DATA_LEN-1:0]     w_data,
   input  logic                    ld_issue,
   input  logic [GPR_ADDR_LEN-1:0] ld_issue_addr,
   input  logic                    ld_valid,
   output logic                    ld_ready,
   input  logic [GPR_ADDR_LEN-1:0] ld_addr,
   input  logic [DATA_LEN-1:0]     ld_data,
   input  logic [OFFSET_LEN-1:0]   ld_offset,
   input  logic [REG_EXT_LEN-1:0]  ld_ext,
   output logic                    rf_we,
   output logic [GPR_ADDR_LEN-1:0] rf_addr,
   output logic [DATA_LEN-1:0]     rf_data,
   output logic [31:0]             pending,
   output logic                    pipe_hold,
   output logic                    ld_busy
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned PW = AW + 1;
   localparam int unsigned CW = 4;

   ld_entry_t           mem_q [FIFO_DEPTH];
   ld_entry_t           mem_d [FIFO_DEPTH];
   logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [31:0]         pending_q, pending_d;
   logic [CW-1:0]       starve_q, starve_d;
   logic                pipe_hold_q, pipe_hold_d;
   logic                ld_busy_q, ld_busy_d;

   logic                fifo_empty, fifo_full;
   logic                push, pop, w_win, head_wr;
   ld_entry_t           head;
   logic [DATA_LEN-1:0] head_data;

   // extra pointer bit separates full from empty when the indices match
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                       (wr_ptr_q[AW] != rd_ptr_q[AW]);
   assign head       = mem_q[rd_ptr_q[AW-1:0]];

   // a W-stage write to $0 is not a write, so it never blocks the FIFO
   assign w_win   = reset_n && w_we && (w_addr != '0);
   assign pop     = !fifo_empty && !w_win;
   assign head_wr = pop && (head.addr != '0);
   assign push    = ld_valid && !fifo_full;

   load_align_ext u_align (
      .data   (head.data),
      .offset (head.offset),
      .ext    (head.ext),
      .data_c (head_data)
   );

   always_comb begin
      rf_we   = 1'b0;
      rf_addr = '0;
      rf_data = '0;
      if (w_win) begin
         rf_we   = 1'b1;
         rf_addr = w_addr;
         rf_data = w_data;
      end else if (head_wr) begin
         rf_we   = 1'b1;
         rf_addr = head.addr;
         rf_data = head_data;
      end
   end

   always_comb begin
      mem_d       = mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      pending_d   = pending_q;
      starve_d    = starve_q;
      pipe_hold_d = pipe_hold_q;

      if (push) begin
         mem_d[wr_ptr_q[AW-1:0]] = '{addr: ld_addr, data: ld_data,
                                     offset: ld_offset, ext: ld_ext};
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);

      // clear first so a same-cycle issue to the same register wins
      if (head_wr) pending_d[head.addr] = 1'b0;
      if (ld_issue && (ld_issue_addr != '0)) pending_d[ld_issue_addr] = 1'b1;

      if (fifo_empty || pop) starve_d = '0;
      else if (starve_q != CW'(STARVE_LIMIT)) starve_d = starve_q + CW'(1);

      if (starve_q == CW'(STARVE_LIMIT)) pipe_hold_d = 1'b1;
      else if (fifo_empty)                pipe_hold_d = 1'b0;

      ld_busy_d = (|pending_d) || (wr_ptr_d != rd_ptr_d);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         pending_q   <= '0;
         starve_q    <= '0;
         pipe_hold_q <= 1'b0;
         ld_busy_q   <= 1'b0;
      end else begin
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         pending_q   <= pending_d;
         starve_q    <= starve_d;
         pipe_hold_q <= pipe_hold_d;
         ld_busy_q   <= ld_busy_d;
      end
   end

   assign ld_ready  = !fifo_full;
   assign pending   = pending_q;
   assign pipe_hold = pipe_hold_q;
   assign ld_busy   = ld_busy_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed vector table, hand-written multi-cycle
// sequences, then randomized traffic against a queue-based reference model.
module tb_wb_port_arbiter;
   import wb_port_arbiter_pkg::*;

   localparam int DEPTH = 2;
   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        w_we, ld_issue, ld_valid;
   logic [4:0]  w_addr, ld_issue_addr, ld_addr;
   logic [31:0] w_data, ld_data;
   logic [1:0]  ld_offset;
   logic [2:0]  ld_ext;
   logic        ld_ready, rf_we, pipe_hold, ld_busy;
   logic [4:0]  rf_addr;
   logic [31:0] rf_data, pending;

   int n_vec = 0;
   int n_err = 0;

   wb_port_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .reset_n(reset_n),
      .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
      .ld_issue(ld_issue), .ld_issue_addr(ld_issue_addr),
      .ld_valid(ld_valid), .ld_ready(ld_ready),
      .ld_addr(ld_addr), .ld_data(ld_data), .ld_offset(ld_offset), .ld_ext(ld_ext),
      .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
      .pending(pending), .pipe_hold(pipe_hold), .ld_busy(ld_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic iss, input logic [4:0] ia,
                        input logic lv, input logic [4:0] la, input logic [31:0] ldd,
                        input logic [1:0] lo, input logic [2:0] le);
      w_we = we; w_addr = wa; w_data = wd;
      ld_issue = iss; ld_issue_addr = ia;
      ld_valid = lv; ld_addr = la; ld_data = ldd; ld_offset = lo; ld_ext = le;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic w_we; logic [4:0] w_addr; logic [31:0] w_data;
      logic iss; logic [4:0] iss_addr;
      logic lv; logic [4:0] la; logic [31:0] ld; logic [1:0] lo; logic [2:0] le;
      logic e_we; logic [4:0] e_addr; logic [31:0] e_data;
      logic e_ready; logic e_hold; logic [31:0] e_pend; logic e_busy;
   } vec_t;

   function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                               input logic iss, input logic [4:0] ia,
                               input logic lv, input logic [4:0] la, input logic [31:0] ldd,
                               input logic [1:0] lo, input logic [2:0] le,
                               input logic ewe, input logic [4:0] ea, input logic [31:0] ed,
                               input logic er, input logic eh, input logic [31:0] ep,
                               input logic eb);
      vec_t v;
      v.w_we = we; v.w_addr = wa; v.w_data = wd; v.iss = iss; v.iss_addr = ia;
      v.lv = lv; v.la = la; v.ld = ldd; v.lo = lo; v.le = le;
      v.e_we = ewe; v.e_addr = ea; v.e_data = ed; v.e_ready = er; v.e_hold = eh;
      v.e_pend = ep; v.e_busy = eb;
      return v;
   endfunction

   // reference model state
   typedef struct packed { logic [4:0] a; logic [31:0] d; logic [1:0] o; logic [2:0] e; } ent_t;
   ent_t        mq[$];
   logic [31:0] m_pend;
   int          m_block;
   bit          m_hold;

   function automatic logic [31:0] fmt(input ent_t x);
      logic [31:0] b, h;
      b = (x.d >> (8 * x.o)) & 32'hFF;
      h = (x.d >> (8 * x.o)) & 32'hFFFF;
      case (x.e)
         3'd0: return x.d;
         3'd1: return (b >= 32'd128) ? (b + 32'hFFFF_FF00) : b;
         3'd2: return b;
         3'd3: return (x.o % 2 != 0) ? 32'h0 : ((h >= 32'h8000) ? (h + 32'hFFFF_0000) : h);
         3'd4: return (x.o % 2 != 0) ? 32'h0 : h;
         default: return 32'h0;
      endcase
   endfunction

   vec_t tbl[$];

   initial begin
      reset_n = 1'b0;
      drive(1, 5'd4, 32'h1111_1111, 0, 0, 0, 0, 0, 0, 0);
      #2;
      chk("rst_ready", 32'(ld_ready), 32'd1);
      chk("rst_rf_we", 32'(rf_we), 32'd0);
      chk("rst_rf_addr", 32'(rf_addr), 32'd0);
      chk("rst_rf_data", rf_data, 32'd0);
      chk("rst_pending", pending, 32'd0);
      chk("rst_hold", 32'(pipe_hold), 32'd0);
      chk("rst_busy", 32'(ld_busy), 32'd0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;

      // ---------------- directed vector table ----------------
      tbl.push_back(mk(0,0,0, 0,0,  0,0,0,0,0,                                1,0,0, 1,0,32'h0,0));
      tbl.push_back(mk(0,0,0, 1,8,  0,0,0,0,0,                                0,0,0, 1,0,32'h0,0));
      tbl.push_back(mk(0,0,0, 0,0,  1,8,32'h80FF1234,3,REG_EXT_BYTE,          0,0,0, 1,0,32'h100,1));
      tbl.push_back(mk(0,0,0, 0,0,  0,0,0,0,0,                 1,8,32'hFFFFFF80, 1,0,32'h100,1));
      tbl.push_back(mk(0,0,0, 0,0,  0,0,0,0,0,                                0,0,0, 1,0,32'h0,0));
      tbl.push_back(mk(0,0,0, 0,0,  1,8,32'h80FF1234,3,REG_EXT_BYTE_U,        0,0,0, 1,0,32'h0,0));
      tbl.push_back(mk(0,0,0, 0,0,  0,0,0,0,0,                 1,8,32'h00000080, 1,0,32'h0,1));
      tbl.push_back(mk(0,0,0, 1,9,  0,0,0,0,0,                                0,0,0, 1,0,32'h0,0));
      tbl.push_back(mk(0,0,0, 0,0,  1,9,32'h9ABC0000,2,REG_EXT_HALF,          0,0,0, 1,0,32'h200,1));
      tbl.push_back(mk(1,3,32'h12345678, 0,0, 0,0,0,0,0,       1,3,32'h12345678, 1,0,32'h200,1));
      tbl.push_back(mk(0,0,0, 0,0,  0,0,0,0,0,                 1,9,32'hFFFF9ABC, 1,0,32'h200,1));
      tbl.push_back(mk(0,0,0, 0,0,  0,0,0,0,0,                                0,0,0, 1,0,32'h0,0));
      tbl.push_back(mk(0,0,0, 1,0,  0,0,0,0,0,                                0,0,0, 1,0,32'h0,0));
      tbl.push_back(mk(0,0,0, 0,0,  0,0,0,0,0,                                0,0,0, 1,0,32'h0,0));
      tbl.push_back(mk(0,0,0, 1,12, 0,0,0,0,0,                                0,0,0, 1,0,32'h0,0));
      tbl.push_back(mk(0,0,0, 0,0,  1,12,32'h000000AB,0,REG_EXT_BYTE_U,       0,0,0, 1,0,32'h1000,1));
      tbl.push_back(mk(0,0,0, 1,12, 0,0,0,0,0,                1,12,32'h000000AB, 1,0,32'h1000,1));
      tbl.push_back(mk(0,0,0, 0,0,  0,0,0,0,0,                                0,0,0, 1,0,32'h1000,1));
      tbl.push_back(mk(0,0,0, 0,0,  1,12,32'hCAFEF00D,1,REG_EXT_NONE,         0,0,0, 1,0,32'h1000,1));
      tbl.push_back(mk(0,0,0, 0,0,  0,0,0,0,0,                1,12,32'hCAFEF00D, 1,0,32'h1000,1));
      tbl.push_back(mk(0,0,0, 0,0,  0,0,0,0,0,                                0,0,0, 1,0,32'h0,0));
      tbl.push_back(mk(0,0,0, 0,0,  1,5,32'h12345678,1,REG_EXT_HALF,          0,0,0, 1,0,32'h0,0));
      tbl.push_back(mk(0,0,0, 0,0,  0,0,0,0,0,                 1,5,32'h00000000, 1,0,32'h0,1));
      tbl.push_back(mk(0,0,0, 0,0,  1,6,32'hFFFFFFFF,0,3'd7,                  0,0,0, 1,0,32'h0,0));
      tbl.push_back(mk(0,0,0, 0,0,  0,0,0,0,0,                 1,6,32'h00000000, 1,0,32'h0,1));
      tbl.push_back(mk(0,0,0, 0,0,  1,7,32'h8001FFFF,2,REG_EXT_HALF_U,        0,0,0, 1,0,32'h0,0));
      tbl.push_back(mk(0,0,0, 0,0,  0,0,0,0,0,                 1,7,32'h00008001, 1,0,32'h0,1));
      tbl.push_back(mk(0,0,0, 0,0,  1,10,32'h00007F00,1,REG_EXT_BYTE,         0,0,0, 1,0,32'h0,0));
      tbl.push_back(mk(1,0,32'hDEAD, 0,0, 0,0,0,0,0,          1,10,32'h0000007F, 1,0,32'h0,1));
      tbl.push_back(mk(0,0,0, 0,0,  0,0,0,0,0,                                0,0,0, 1,0,32'h0,0));
      tbl[0].e_we = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].w_we, tbl[i].w_addr, tbl[i].w_data, tbl[i].iss, tbl[i].iss_addr,
               tbl[i].lv, tbl[i].la, tbl[i].ld, tbl[i].lo, tbl[i].le);
         @(negedge clk);
         chk($sformatf("tbl%0d_rf_we", i), 32'(rf_we), 32'(tbl[i].e_we));
         chk($sformatf("tbl%0d_rf_addr", i), 32'(rf_addr), 32'(tbl[i].e_addr));
         chk($sformatf("tbl%0d_rf_data", i), rf_data, tbl[i].e_data);
         chk($sformatf("tbl%0d_ready", i), 32'(ld_ready), 32'(tbl[i].e_ready));
         chk($sformatf("tbl%0d_hold", i), 32'(pipe_hold), 32'(tbl[i].e_hold));
         chk($sformatf("tbl%0d_pending", i), pending, tbl[i].e_pend);
         chk($sformatf("tbl%0d_busy", i), 32'(ld_busy), 32'(tbl[i].e_busy));
         next_cycle();
      end

      // ---------------- full FIFO and starvation ----------------
      drive(1, 3, 32'h1, 0, 0, 1, 20, 32'h11, 0, REG_EXT_BYTE_U);
      @(negedge clk); chk("stv_ready_a", 32'(ld_ready), 32'd1); next_cycle();
      drive(1, 3, 32'h1, 0, 0, 1, 21, 32'h22, 0, REG_EXT_BYTE_U);
      @(negedge clk); chk("stv_ready_b", 32'(ld_ready), 32'd1); next_cycle();
      for (int k = 0; k < 4; k++) begin
         drive(1, 3, 32'h1, 0, 0, 1, 22, 32'h33, 0, REG_EXT_BYTE_U);
         @(negedge clk);
         chk($sformatf("stv_full%0d", k), 32'(ld_ready), 32'd0);
         chk($sformatf("stv_nohold%0d", k), 32'(pipe_hold), 32'd0);
         chk($sformatf("stv_wwin%0d", k), 32'(rf_addr), 32'd3);
         next_cycle();
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("stv_hold_g", 32'(pipe_hold), 32'd1);
      chk("stv_pop1_addr", 32'(rf_addr), 32'd20);
      chk("stv_pop1_data", rf_data, 32'h11);
      next_cycle();
      @(negedge clk);
      chk("stv_hold_h", 32'(pipe_hold), 32'd1);
      chk("stv_pop2_addr", 32'(rf_addr), 32'd21);
      chk("stv_pop2_data", rf_data, 32'h22);
      next_cycle();
      @(negedge clk);
      chk("stv_hold_i", 32'(pipe_hold), 32'd1);
      chk("stv_empty_we", 32'(rf_we), 32'd0);
      next_cycle();
      @(negedge clk);
      chk("stv_hold_j", 32'(pipe_hold), 32'd0);
      chk("stv_busy_j", 32'(ld_busy), 32'd0);
      next_cycle();

      // ---------------- zero-register drain ----------------
      drive(0, 0, 0, 0, 0, 1, 0, 32'hFFFF_FFFF, 0, REG_EXT_NONE);
      @(negedge clk); chk("z_busy0", 32'(ld_busy), 32'd0); next_cycle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("z_rf_we", 32'(rf_we), 32'd0);
      chk("z_busy1", 32'(ld_busy), 32'd1);
      next_cycle();
      @(negedge clk); chk("z_busy2", 32'(ld_busy), 32'd0); next_cycle();

      // ---------------- reset mid-stream ----------------
      drive(1, 4, 32'h4444, 1, 15, 1, 16, 32'h55, 0, REG_EXT_NONE);
      next_cycle();
      drive(1, 4, 32'h4444, 0, 0, 1, 17, 32'h66, 0, REG_EXT_NONE);
      repeat (7) next_cycle();
      @(negedge clk);
      chk("mr_pre_hold", 32'(pipe_hold), 32'd1);
      chk("mr_pre_pend", pending, 32'h0000_8000);
      chk("mr_pre_ready", 32'(ld_ready), 32'd0);
      #2 reset_n = 1'b0;
      #1;
      chk("mr_ready", 32'(ld_ready), 32'd1);
      chk("mr_pending", pending, 32'd0);
      chk("mr_rf_we", 32'(rf_we), 32'd0);
      chk("mr_rf_addr", 32'(rf_addr), 32'd0);
      chk("mr_rf_data", rf_data, 32'd0);
      chk("mr_hold", 32'(pipe_hold), 32'd0);
      chk("mr_busy", 32'(ld_busy), 32'd0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1 reset_n = 1'b1;

      // ---------------- randomized traffic vs reference model ----------------
      mq.delete();
      m_pend  = '0;
      m_block = 0;
      m_hold  = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         int          size;
         bit          wwin, do_pop, hold_next;
         logic        e_we;
         logic [4:0]  e_addr, ra;
         logic [31:0] e_data;
         ent_t        ne;

         ra = 5'($urandom_range(0, 31));
         w_addr = ra;
         w_data = $urandom;
         if ((c % 600) < 300) w_we = ($urandom_range(0, 7) != 0);
         else                 w_we = ($urandom_range(0, 1) != 0);
         if (m_hold || m_pend[ra]) w_we = 1'b0;
         ld_issue_addr = 5'($urandom_range(0, 31));
         ld_issue = ($urandom_range(0, 3) == 0) && !m_pend[ld_issue_addr];
         ld_valid = ($urandom_range(0, 1) != 0);
         ld_addr = 5'($urandom_range(0, 31));
         ld_data = $urandom;
         ld_offset = 2'($urandom_range(0, 3));
         ld_ext = 3'($urandom_range(0, 7));

         @(negedge clk);
         size   = mq.size();
         wwin   = w_we && (w_addr != 0);
         do_pop = (size > 0) && !wwin;
         e_we = 1'b0; e_addr = '0; e_data = '0;
         if (wwin) begin
            e_we = 1'b1; e_addr = w_addr; e_data = w_data;
         end else if (do_pop && mq[0].a != 0) begin
            e_we = 1'b1; e_addr = mq[0].a; e_data = fmt(mq[0]);
         end
         chk("rnd_rf_we", 32'(rf_we), 32'(e_we));
         chk("rnd_rf_addr", 32'(rf_addr), 32'(e_addr));
         chk("rnd_rf_data", rf_data, e_data);
         chk("rnd_ready", 32'(ld_ready), 32'(size < DEPTH));
         chk("rnd_pending", pending, m_pend);
         chk("rnd_hold", 32'(pipe_hold), 32'(m_hold));
         chk("rnd_busy", 32'(ld_busy), 32'((m_pend != 0) || (size > 0)));

         hold_next = m_hold;
         if (m_block >= LIMIT) hold_next = 1'b1;
         else if (size == 0)   hold_next = 1'b0;
         if (do_pop) begin
            if (mq[0].a != 0) m_pend[mq[0].a] = 1'b0;
            void'(mq.pop_front());
         end
         if (ld_valid && size < DEPTH) begin
            ne.a = ld_addr; ne.d = ld_data; ne.o = ld_offset; ne.e = ld_ext;
            mq.push_back(ne);
         end
         if (ld_issue && ld_issue_addr != 0) m_pend[ld_issue_addr] = 1'b1;
         m_block = (size == 0 || do_pop) ? 0 : m_block + 1;
         m_hold  = hold_next;
         next_cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
